// File: rtl/rne_arb.sv
// rne_arb: round-robin arbiter sharing a 2-stage round-to-nearest-even 16->8 bit datapath
// ports: req_valid/req_data/req_ready per-requester handshake and operands,
//        out_valid/out_ready/out_data/out_id/out_ovf rounded result with source id and saturation flag,
//        ovf_count saturating tally of delivered overflowed results
module rne_arb #(
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic [IDW-1:0]       out_id,
  output logic                 out_ovf,
  output logic [7:0]           ovf_count
);
  logic [IDW-1:0] r_ptr, r_s1_id, r_s2_id, w_gid, w_j;
  logic           r_s1_valid, r_s2_valid, r_s2_ovf, w_any, w_adv1, w_adv2, w_xfer, w_up;
  logic [15:0]    r_s1_data;
  logic [15:0]    w_ops [NREQ];
  logic [7:0]     r_s2_data, r_cnt;
  logic [8:0]     w_sum;
  for (genvar i = 0; i < NREQ; i++) begin : g_ops
    assign w_ops[i] = req_data[16*i +: 16];
  end
  // scan from farthest to nearest so the requester right after r_ptr wins
  always_comb begin
    w_any = 1'b0;
    w_gid = '0;
    w_j   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_j = IDW'((int'(r_ptr) + k) % NREQ);
      if (req_valid[w_j]) begin
        w_any = 1'b1;
        w_gid = w_j;
      end
    end
  end
  assign w_adv2    = !r_s2_valid | out_ready;
  assign w_adv1    = !r_s1_valid | w_adv2;
  assign w_xfer    = w_any & w_adv1 & !reset;
  assign req_ready = w_xfer ? NREQ'(1) << w_gid : '0;
  assign w_up      = r_s1_data[7] & (|r_s1_data[6:0] | r_s1_data[8]);
  assign w_sum     = {1'b0, r_s1_data[15:8]} + {8'd0, w_up};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr      <= IDW'(NREQ - 1);
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_id    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_id    <= '0;
      r_s2_ovf   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_adv1) r_s1_valid <= w_xfer;
      if (w_xfer) begin
        r_s1_data <= w_ops[w_gid];
        r_s1_id   <= w_gid;
        r_ptr     <= w_gid;
      end
      if (w_adv2) begin
        r_s2_valid <= r_s1_valid;
        r_s2_data  <= w_sum[8] ? 8'hFF : w_sum[7:0];
        r_s2_id    <= r_s1_id;
        r_s2_ovf   <= w_sum[8];
      end
      if (r_s2_valid & out_ready & r_s2_ovf & ~&r_cnt) r_cnt <= r_cnt + 8'd1;
    end
  end
  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_id    = r_s2_id;
  assign out_ovf   = r_s2_ovf;
  assign ovf_count = r_cnt;
endmodule

// File: doc/rne_arb.md
Name: rne_arb

Overview:
- Shares one registered round-to-nearest-even (RNE) datapath among NREQ requesters.
- Each requester offers a 16-bit unsigned fixed-point value. The block arbitrates round-robin, rounds the value to 8 bits in a 2-stage pipeline, and returns the result tagged with the requester id.
- Sits between the multiplier/accumulator lanes and the 8-bit writeback path. Supports full valid/ready backpressure.

Parameters:
- NREQ, 4, number of requesters (2..16).
- IDW, 2, id width; must equal clog2(NREQ).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  bit i: requester i offers an operand.
- req_data  in  16*NREQ  operand i in bits [16*i+15:16*i].
- req_ready  out  NREQ  bit i: operand i is accepted this cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  8  rounded result.
- out_id  out  IDW  requester index of the result.
- out_ovf  out  1  rounding overflowed; result saturated.
- ovf_count  out  8  saturating count of overflowed results delivered.

Behaviour:
- Reset (clk edge with reset=1):
  - s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_id=0, out_ovf=0, ovf_count=0.
  - RR pointer = NREQ-1, so requester 0 has top priority first.
  - In-flight operands are discarded; req_ready=0 while reset is high.
- Pipeline registers:
  - S1 holds {operand, id}.
  - S2 holds {z, id, ovf}; S2 drives out_*.
- Advance rules:
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
- Arbitration (combinational):
  - Search starts at (ptr+1) mod NREQ, wrapping. The first i with req_valid[i]=1 is granted.
  - req_ready[i] = grant[i] & adv1 & !reset. At most one bit is set; no grant if no valid.
  - req_ready is combinationally dependent on out_ready and req_valid.
- Transfer on requester i: req_valid[i]&req_ready[i].
  - S1 loads {req_data_i, i}; s1_valid=1.
  - ptr updates to i. ptr does not update without a transfer.
- If adv1 is true and there is no transfer, s1_valid becomes 0.
- On adv2, S2 loads from S1, and s2_valid takes the value of s1_valid.
- If adv2 is false, S1 and S2 hold and out_* stay stable.
- Latency: a transfer at edge N gives out_valid at edge N+2 with no stall. Throughput is 1 per cycle.
- Rounding arithmetic on operand a[15:0]:
  - lsb=a[8], guard=a[7], sticky=|a[6:0].
  - up = guard & (sticky | lsb).
  - {c, z} = a[15:8] + up (9 bits).
  - If c=1: z=8'hFF and ovf=1. Otherwise ovf=0.
  - This is pure RNE with ties-to-even and saturation.
- ovf_count increments on each out_valid&out_ready&out_ovf and sticks at 255.
- Simultaneous events:
  - A new grant and a result handoff in the same cycle is allowed; the pipeline stays full with no bubble.
  - A requester dropping req_valid before it is granted is legal; no state changes.
  - A requester must hold req_valid and req_data stable until its transfer.
- Out-of-range ids cannot occur; NREQ need not be a power of 2, and the wrap is at NREQ-1.

Test Plan:
- Rounding vectors, single requester 0, out_ready=1:
  - 0x1280 -> 0x12 (tie, even); 0x1380 -> 0x14; 0x1281 -> 0x13; 0x127F -> 0x12; 0x0000 -> 0x00.
  - 0xFF80 -> 0xFF with out_ovf=1.
  - Each result appears exactly 2 cycles after its transfer, with out_id=0.
- Fairness: all 4 req_valid held high, out_ready=1 for 8 cycles.
  - Grants are 0,1,2,3,0,1,2,3.
  - out_id follows the same sequence, with one result per cycle after a 2-cycle fill.
- Backpressure: pipeline full, out_ready=0 for 5 cycles.
  - req_ready=0 throughout; out_data/out_id stay stable.
  - On release, results drain in order with no loss or duplication.
- Sparse requests: only requesters 1 and 3 valid.
  - Grants alternate 1,3,1,3.
  - With ptr=3 and only requester 3 valid, requester 3 is granted again.
- Reset mid-operation: reset asserted with both stages full.
  - Next cycle out_valid=0, ovf_count=0.
  - First grant after reset goes to the lowest valid index.
- Counter: 300 overflowing operands (0xFFFF) delivered -> ovf_count=255 and holds there.
